// File: rtl/riscv16_pkg.sv
// Shared RISCV16 definitions: datapath widths, writeback select / load type
// encodings and the writeback stage state type.
package riscv16_pkg;

  localparam int XLEN = 16;
  localparam int RA_W = 4;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_LINK = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    LD_WORD  = 2'b00,
    LD_BYTE  = 2'b01,
    LD_BYTEU = 2'b10,
    LD_WORD3 = 2'b11
  } ld_type_e;

  typedef enum logic {
    WB_IDLE     = 1'b0,
    WB_WAIT_MEM = 1'b1
  } wb_state_e;

endpackage

// File: rtl/load_formatter.sv
// Combinational load-data formatter: word pass-through or byte extract with
// sign/zero extension. Shared by the MEM and writeback stages.
module load_formatter
  import riscv16_pkg::*;
#(
  parameter int XLEN = riscv16_pkg::XLEN
) (
  input  logic [XLEN-1:0] i_mem_rdata,
  input  logic [1:0]      i_ld_type,
  input  logic            i_byte_sel,
  output logic [XLEN-1:0] o_result
);

  logic [7:0] w_byte;

  assign w_byte = i_byte_sel ? i_mem_rdata[15:8] : i_mem_rdata[7:0];

  always_comb begin
    unique case (i_ld_type)
      LD_BYTE:  o_result = {{(XLEN-8){w_byte[7]}}, w_byte};
      LD_BYTEU: o_result = {{(XLEN-8){1'b0}}, w_byte};
      default:  o_result = i_mem_rdata;  // LD_WORD and the unused 2'b11 code
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// RISCV16 writeback stage: selects the result, waits on load data, drives the
// registered register-bank write port and counts retired instructions.
module writeback_unit
  import riscv16_pkg::*;
#(
  parameter int XLEN = riscv16_pkg::XLEN,
  parameter int RA_W = riscv16_pkg::RA_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_rd_en,
  input  logic [RA_W-1:0] in_rd_addr,
  input  logic [1:0]      in_wb_sel,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_pc_plus2,
  input  logic [1:0]      in_ld_type,
  input  logic            in_byte_sel,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_rvalid,
  output logic            reg_we,
  output logic [RA_W-1:0] reg_rd_addr,
  output logic [XLEN-1:0] reg_rd_data,
  output logic            wb_commit,
  output logic [15:0]     retired_count
);

  wb_state_e       r_state;
  wb_state_e       w_next_state;

  // Load context captured at accept, used when the memory response arrives.
  logic            r_ld_rd_en;
  logic [RA_W-1:0] r_ld_rd_addr;
  logic [1:0]      r_ld_type;
  logic            r_ld_byte_sel;

  logic            w_accept;
  logic            w_capture_load;
  logic            w_commit;
  logic            w_we;
  logic [RA_W-1:0] w_addr;
  logic [XLEN-1:0] w_data;
  logic [XLEN-1:0] w_ld_data;

  assign in_ready = (r_state == WB_IDLE);
  assign w_accept = in_valid && in_ready;

  load_formatter #(.XLEN(XLEN)) u_load_formatter (
    .i_mem_rdata (mem_rdata),
    .i_ld_type   (r_ld_type),
    .i_byte_sel  (r_ld_byte_sel),
    .o_result    (w_ld_data)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; that is what keeps this block free of inferred latches.
    w_next_state   = r_state;
    w_capture_load = 1'b0;
    w_commit       = 1'b0;
    w_we           = 1'b0;
    w_addr         = reg_rd_addr;
    w_data         = reg_rd_data;

    unique case (r_state)
      WB_IDLE: begin
        if (w_accept) begin
          if (in_wb_sel == WB_LOAD) begin
            w_capture_load = 1'b1;
            w_next_state   = WB_WAIT_MEM;
          end else begin
            w_commit = 1'b1;
            w_we     = in_rd_en && (in_rd_addr != '0) && (in_wb_sel != WB_RSVD);
            w_addr   = in_rd_addr;
            w_data   = (in_wb_sel == WB_LINK) ? in_pc_plus2 : in_alu_result;
          end
        end
      end
      WB_WAIT_MEM: begin
        if (mem_rvalid) begin
          w_commit     = 1'b1;
          w_we         = r_ld_rd_en && (r_ld_rd_addr != '0);
          w_addr       = r_ld_rd_addr;
          w_data       = w_ld_data;
          w_next_state = WB_IDLE;
        end
      end
      default: w_next_state = WB_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= WB_IDLE;
      r_ld_rd_en    <= 1'b0;
      r_ld_rd_addr  <= '0;
      r_ld_type     <= LD_WORD;
      r_ld_byte_sel <= 1'b0;
      reg_we        <= 1'b0;
      reg_rd_addr   <= '0;
      reg_rd_data   <= '0;
      wb_commit     <= 1'b0;
      retired_count <= 16'h0000;
    end else begin
      r_state     <= w_next_state;
      reg_we      <= w_we;
      reg_rd_addr <= w_addr;
      reg_rd_data <= w_data;
      wb_commit   <= w_commit;
      if (w_capture_load) begin
        r_ld_rd_en    <= in_rd_en;
        r_ld_rd_addr  <= in_rd_addr;
        r_ld_type     <= in_ld_type;
        r_ld_byte_sel <= in_byte_sel;
      end
      if (w_commit) retired_count <= retired_count + 16'd1;  // wraps naturally
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit: one task per scenario,
// inputs driven and outputs sampled on the falling edge.
module tb_writeback_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_rd_en;
  logic [3:0]  in_rd_addr;
  logic [1:0]  in_wb_sel;
  logic [15:0] in_alu_result;
  logic [15:0] in_pc_plus2;
  logic [1:0]  in_ld_type;
  logic        in_byte_sel;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic        reg_we;
  logic [3:0]  reg_rd_addr;
  logic [15:0] reg_rd_data;
  logic        wb_commit;
  logic [15:0] retired_count;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_count = 16'h0000;

  writeback_unit dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rd_en      (in_rd_en),
    .in_rd_addr    (in_rd_addr),
    .in_wb_sel     (in_wb_sel),
    .in_alu_result (in_alu_result),
    .in_pc_plus2   (in_pc_plus2),
    .in_ld_type    (in_ld_type),
    .in_byte_sel   (in_byte_sel),
    .mem_rdata     (mem_rdata),
    .mem_rvalid    (mem_rvalid),
    .reg_we        (reg_we),
    .reg_rd_addr   (reg_rd_addr),
    .reg_rd_data   (reg_rd_data),
    .wb_commit     (wb_commit),
    .retired_count (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_op(input logic v, input logic en, input logic [3:0] rd,
                          input logic [1:0] sel, input logic [15:0] alu,
                          input logic [15:0] pc, input logic [1:0] ld,
                          input logic bsel);
    in_valid      = v;
    in_rd_en      = en;
    in_rd_addr    = rd;
    in_wb_sel     = sel;
    in_alu_result = alu;
    in_pc_plus2   = pc;
    in_ld_type    = ld;
    in_byte_sel   = bsel;
  endtask

  task automatic drive_idle();
    drive_op(1'b0, 1'b0, 4'd0, 2'b00, 16'h0, 16'h0, 2'b00, 1'b0);
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    mem_rvalid = 1'b0;
    mem_rdata  = 16'h0000;
    drive_idle();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({in_ready, wb_commit, reg_we, reg_rd_addr, reg_rd_data, retired_count}
        !== {1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000}) begin
      n_err++;
      $display("FAIL reset_values got rdy=%0b c=%0b we=%0b a=%0d d=%h cnt=%h want rdy=1 c=0 we=0 a=0 d=0000 cnt=0000",
               in_ready, wb_commit, reg_we, reg_rd_addr, reg_rd_data, retired_count);
    end
    rst = 1'b0;
    // A response with nothing outstanding must not retire anything.
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hDEAD;
    @(negedge clk);
    mem_rvalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({wb_commit, reg_we, retired_count, in_ready} !== {1'b0, 1'b0, 16'h0000, 1'b1}) begin
      n_err++;
      $display("FAIL idle_rvalid_ignored got c=%0b we=%0b cnt=%h rdy=%0b want c=0 we=0 cnt=0000 rdy=1",
               wb_commit, reg_we, retired_count, in_ready);
    end
  endtask

  task automatic test_back_to_back_alu();
    drive_op(1'b1, 1'b1, 4'd3, 2'b00, 16'h1234, 16'h0, 2'b00, 1'b0);
    @(negedge clk);
    exp_count = exp_count + 16'd1;
    n_cmp++;
    if ({wb_commit, reg_we, reg_rd_addr, reg_rd_data, in_ready}
        !== {1'b1, 1'b1, 4'd3, 16'h1234, 1'b1}) begin
      n_err++;
      $display("FAIL alu_first got c=%0b we=%0b a=%0d d=%h rdy=%0b want c=1 we=1 a=3 d=1234 rdy=1",
               wb_commit, reg_we, reg_rd_addr, reg_rd_data, in_ready);
    end
    drive_op(1'b1, 1'b1, 4'd4, 2'b00, 16'hBEEF, 16'h0, 2'b00, 1'b0);
    @(negedge clk);
    exp_count = exp_count + 16'd1;
    n_cmp++;
    if ({wb_commit, reg_we, reg_rd_addr, reg_rd_data, in_ready, retired_count}
        !== {1'b1, 1'b1, 4'd4, 16'hBEEF, 1'b1, 16'd2}) begin
      n_err++;
      $display("FAIL alu_second got c=%0b we=%0b a=%0d d=%h rdy=%0b cnt=%h want c=1 we=1 a=4 d=beef rdy=1 cnt=0002",
               wb_commit, reg_we, reg_rd_addr, reg_rd_data, in_ready, retired_count);
    end
    drive_idle();
    @(negedge clk);
    n_cmp++;
    if ({wb_commit, reg_we, reg_rd_addr, reg_rd_data} !== {1'b0, 1'b0, 4'd4, 16'hBEEF}) begin
      n_err++;
      $display("FAIL alu_hold got c=%0b we=%0b a=%0d d=%h want c=0 we=0 a=4 d=beef",
               wb_commit, reg_we, reg_rd_addr, reg_rd_data);
    end
  endtask

  // Load to rd=5, response with 0x80FF three cycles after the accept.
  task automatic test_load(input string name, input logic [1:0] ld,
                           input logic bsel, input logic [15:0] exp_data);
    logic wait_ok;
    wait_ok = 1'b1;
    drive_op(1'b1, 1'b1, 4'd5, 2'b01, 16'h5555, 16'h0, ld, bsel);
    @(negedge clk);
    drive_idle();
    mem_rdata = 16'h1111;
    for (int i = 0; i < 2; i++) begin
      if (in_ready !== 1'b0 || wb_commit !== 1'b0 || reg_we !== 1'b0) wait_ok = 1'b0;
      @(negedge clk);
    end
    if (in_ready !== 1'b0 || wb_commit !== 1'b0) wait_ok = 1'b0;
    n_cmp++;
    if (wait_ok !== 1'b1) begin
      n_err++;
      $display("FAIL %s_wait got rdy=%0b c=%0b want rdy=0 c=0 throughout", name, in_ready, wb_commit);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 16'h80FF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = 16'h2222;
    exp_count  = exp_count + 16'd1;
    n_cmp++;
    if ({wb_commit, reg_we, reg_rd_addr, reg_rd_data, in_ready, retired_count}
        !== {1'b1, 1'b1, 4'd5, exp_data, 1'b1, exp_count}) begin
      n_err++;
      $display("FAIL %s_commit got c=%0b we=%0b a=%0d d=%h rdy=%0b cnt=%h want c=1 we=1 a=5 d=%h rdy=1 cnt=%h",
               name, wb_commit, reg_we, reg_rd_addr, reg_rd_data, in_ready, retired_count,
               exp_data, exp_count);
    end
    @(negedge clk);
  endtask

  task automatic test_no_write();
    drive_op(1'b1, 1'b1, 4'd0, 2'b00, 16'hAAAA, 16'h0, 2'b00, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({wb_commit, reg_we} !== 2'b10) begin
      n_err++;
      $display("FAIL rd0_nowrite got c=%0b we=%0b want c=1 we=0", wb_commit, reg_we);
    end
    drive_op(1'b1, 1'b0, 4'd6, 2'b00, 16'hBBBB, 16'h0, 2'b00, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({wb_commit, reg_we} !== 2'b10) begin
      n_err++;
      $display("FAIL rden0_nowrite got c=%0b we=%0b want c=1 we=0", wb_commit, reg_we);
    end
    drive_op(1'b1, 1'b1, 4'd7, 2'b11, 16'hCCCC, 16'h0, 2'b00, 1'b0);
    @(negedge clk);
    exp_count = exp_count + 16'd3;
    n_cmp++;
    if ({wb_commit, reg_we, retired_count} !== {1'b1, 1'b0, exp_count}) begin
      n_err++;
      $display("FAIL rsvd_nowrite got c=%0b we=%0b cnt=%h want c=1 we=0 cnt=%h",
               wb_commit, reg_we, retired_count, exp_count);
    end
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    drive_op(1'b1, 1'b1, 4'd9, 2'b01, 16'h0, 16'h0, 2'b00, 1'b0);
    @(negedge clk);
    drive_idle();
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL midwait_enter got rdy=%0b want rdy=0", in_ready);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready, wb_commit, reg_we, reg_rd_addr, reg_rd_data, retired_count}
        !== {1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000}) begin
      n_err++;
      $display("FAIL midwait_async_clear got rdy=%0b c=%0b we=%0b a=%0d d=%h cnt=%h want 1/0/0/0/0000/0000",
               in_ready, wb_commit, reg_we, reg_rd_addr, reg_rd_data, retired_count);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_count = 16'h0000;
    mem_rvalid = 1'b1;
    mem_rdata  = 16'h7777;
    @(negedge clk);
    mem_rvalid = 1'b0;
    n_cmp++;
    if ({in_ready, wb_commit, reg_we, reg_rd_addr, reg_rd_data, retired_count}
        !== {1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000}) begin
      n_err++;
      $display("FAIL midwait_discard got rdy=%0b c=%0b we=%0b a=%0d d=%h cnt=%h want 1/0/0/0/0000/0000",
               in_ready, wb_commit, reg_we, reg_rd_addr, reg_rd_data, retired_count);
    end
  endtask

  task automatic test_link();
    drive_op(1'b1, 1'b1, 4'd1, 2'b10, 16'h9999, 16'h0042, 2'b00, 1'b0);
    @(negedge clk);
    drive_idle();
    exp_count = exp_count + 16'd1;
    n_cmp++;
    if ({wb_commit, reg_we, reg_rd_addr, reg_rd_data, retired_count}
        !== {1'b1, 1'b1, 4'd1, 16'h0042, exp_count}) begin
      n_err++;
      $display("FAIL link got c=%0b we=%0b a=%0d d=%h cnt=%h want c=1 we=1 a=1 d=0042 cnt=%h",
               wb_commit, reg_we, reg_rd_addr, reg_rd_data, retired_count, exp_count);
    end
  endtask

  task automatic test_count_wrap();
    int n_fill;
    n_fill = 65535 - int'(exp_count);
    drive_op(1'b1, 1'b0, 4'd2, 2'b00, 16'h0101, 16'h0, 2'b00, 1'b0);
    repeat (n_fill) @(negedge clk);
    drive_idle();
    n_cmp++;
    if ({wb_commit, retired_count} !== {1'b1, 16'hFFFF}) begin
      n_err++;
      $display("FAIL count_full got c=%0b cnt=%h want c=1 cnt=ffff", wb_commit, retired_count);
    end
    @(negedge clk);
    drive_op(1'b1, 1'b1, 4'd8, 2'b00, 16'h0808, 16'h0, 2'b00, 1'b0);
    @(negedge clk);
    drive_idle();
    n_cmp++;
    if ({wb_commit, reg_we, reg_rd_addr, reg_rd_data, retired_count}
        !== {1'b1, 1'b1, 4'd8, 16'h0808, 16'h0000}) begin
      n_err++;
      $display("FAIL count_wrap got c=%0b we=%0b a=%0d d=%h cnt=%h want c=1 we=1 a=8 d=0808 cnt=0000",
               wb_commit, reg_we, reg_rd_addr, reg_rd_data, retired_count);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back_alu();
    test_load("ld_byte_hi",  2'b01, 1'b1, 16'hFF80);
    test_load("ld_byteu_hi", 2'b10, 1'b1, 16'h0080);
    test_load("ld_word",     2'b00, 1'b1, 16'h80FF);
    test_load("ld_byte_lo",  2'b01, 1'b0, 16'hFFFF);
    test_load("ld_byteu_lo", 2'b10, 1'b0, 16'h00FF);
    test_load("ld_type3",    2'b11, 1'b0, 16'h80FF);
    test_no_write();
    test_reset_mid_wait();
    test_link();
    test_count_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
